// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the default data-memory depth.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int LSU_MEM_WORDS = 8192;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling for sub-word accesses: extracts and extends a
// byte/half from a memory word on loads, and merges new store data into the
// addressed lane of the old word for read-modify-write stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] new_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;

    // Halves use only addr[1]; word accesses are aligned so the shift is zero.
    always_comb begin
        shamt     = (size_i == SZ_HALF) ? {lane_i[1], 4'b0000} : {lane_i, 3'b000};
        shifted   = word_i >> shamt;
        lane_mask = (size_i == SZ_HALF) ? (32'h0000_FFFF << shamt)
                                        : (32'h0000_00FF << shamt);
        case (size_i)
            SZ_BYTE: ld_data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            default: ld_data_o = shifted;
        endcase
        st_word_o = (word_i & ~lane_mask) | ((new_i << shamt) & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns single CPU load/store requests into word-wide
// memory strobes. Sub-word stores are done as read-modify-write since the
// memory has no byte enables. One request in flight at a time.
// Optional: define LSU_STATS_EN to add saturating completion counters
// (stat_loads, stat_stores, stat_errs).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int MEM_WORDS = LSU_MEM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef LSU_STATS_EN
    ,
    output logic [15:0] stat_loads,
    output logic [15:0] stat_stores,
    output logic [15:0] stat_errs
`endif
);

    lsu_state_t  state_q;
    logic        ready_q, rd_q, wr_q, rv_q, err_q;
    logic [31:0] addr_q, mwdata_q, rdata_q, nwdata_q;
    logic        write_q, signed_q;
    logic [1:0]  size_q, lane_q, cnt_q;
    logic        req_err;
    logic [31:0] ld_data, st_word;

    // Rejected accesses: illegal size, misalignment, or word index past the end.
    always_comb begin
        req_err = (req_size == 2'b11)
               || (req_size == SZ_HALF && req_addr[0])
               || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
               || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    end

    lsu_lane_align u_align (
        .word_i    (mem_rdata),
        .lane_i    (lane_q),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .new_i     (nwdata_q),
        .ld_data_o (ld_data),
        .st_word_o (st_word)
    );

    // Access FSM; every interface output is a register set on state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            mwdata_q <= '0;
            rdata_q  <= '0;
            nwdata_q <= '0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= SZ_BYTE;
            lane_q   <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ready_q && req_valid) begin
                        ready_q  <= 1'b0;
                        write_q  <= req_write;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        lane_q   <= req_addr[1:0];
                        nwdata_q <= req_wdata;
                        if (req_err) begin
                            state_q <= ST_RESP;
                            rv_q    <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (req_write && req_size == SZ_WORD) begin
                            state_q  <= ST_WRITE;
                            addr_q   <= {req_addr[31:2], 2'b00};
                            wr_q     <= 1'b1;
                            mwdata_q <= req_wdata;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            state_q <= ST_RD_WAIT;
                            addr_q  <= {req_addr[31:2], 2'b00};
                            rd_q    <= 1'b1;
                            cnt_q   <= 2'(RD_LAT - 1);
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt_q == 2'd0) begin
                        rd_q <= 1'b0;
                        if (write_q) begin
                            state_q  <= ST_WRITE;
                            wr_q     <= 1'b1;
                            mwdata_q <= st_word;
                        end else begin
                            state_q <= ST_RESP;
                            rv_q    <= 1'b1;
                            rdata_q <= ld_data;
                        end
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ST_WRITE: begin
                    state_q  <= ST_RESP;
                    wr_q     <= 1'b0;
                    mwdata_q <= '0;
                    rv_q     <= 1'b1;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    rv_q    <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    addr_q  <= '0;
                    ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = rv_q;
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = addr_q;
    assign mem_read   = rd_q;
    assign mem_write  = wr_q;
    assign mem_wdata  = mwdata_q;

`ifdef LSU_STATS_EN
    logic [15:0] st_ld_q, st_st_q, st_er_q;

    // Saturating completion counters, advanced out of the response cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_ld_q <= '0;
            st_st_q <= '0;
            st_er_q <= '0;
        end else if (state_q == ST_RESP) begin
            if (err_q) begin
                if (st_er_q != 16'hFFFF) st_er_q <= st_er_q + 16'd1;
            end else if (write_q) begin
                if (st_st_q != 16'hFFFF) st_st_q <= st_st_q + 16'd1;
            end else begin
                if (st_ld_q != 16'hFFFF) st_ld_q <= st_ld_q + 16'd1;
            end
        end
    end

    assign stat_loads  = st_ld_q;
    assign stat_stores = st_st_q;
    assign stat_errs   = st_er_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a transaction-level model predicts the output
// trace of every cycle from the request rules, and a compare process checks
// the DUT against it each cycle. Directed cases pin literal results.
module tb_load_store_unit;

    localparam int RD_LAT    = 1;
    localparam int MEM_WORDS = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] ram     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.RD_LAT(RD_LAT), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory device: read data valid within the read cycle, writes at the edge.
    assign mem_rdata = ram[mem_addr[14:2]];
    always @(posedge clk) if (mem_write) ram[mem_addr[14:2]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs for one cycle. achk=0 marks mem_addr as don't-care.
    typedef struct packed {
        logic        rdy, rd, wr, rv, err, achk;
        logic [31:0] addr, wdata, rdata;
    } cyc_t;

    cyc_t expq[$];
    cyc_t cur;

    function automatic cyc_t mk(input logic rd, input logic wr, input logic rv, input logic err,
                                input logic achk, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata);
        cyc_t c;
        c = '0;
        c.rd = rd; c.wr = wr; c.rv = rv; c.err = err; c.achk = achk;
        c.addr = addr; c.wdata = wdata; c.rdata = rdata;
        return c;
    endfunction

    // Build the cycle trace of one accepted request from the access rules.
    function automatic void gen(input logic wr_i, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd);
        int unsigned wi;
        int          lane, sh;
        logic [31:0] al, old, v, m, res;
        bit          bad;
        wi   = a[31:2];
        lane = a[1:0];
        al   = a & 32'hFFFF_FFFC;
        bad  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && lane != 0)
            || (wi >= MEM_WORDS);
        if (bad) begin
            expq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0));
            return;
        end
        old = ref_mem[wi];
        sh  = (sz == 2'b00) ? 8 * lane : 16 * (lane / 2);
        m   = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
        if (!wr_i) begin
            if (sz == 2'b10) res = old;
            else begin
                v = (old >> sh) & m;
                if (sg && sz == 2'b00 && v >= 128)   res = v + 32'hFFFF_FF00;
                else if (sg && sz == 2'b01 && v >= 32768) res = v + 32'hFFFF_0000;
                else res = v;
            end
            for (int i = 0; i < RD_LAT; i++) expq.push_back(mk(1, 0, 0, 0, 1, al, 0, 0));
            expq.push_back(mk(0, 0, 1, 0, 0, al, 0, res));
        end else if (sz == 2'b10) begin
            expq.push_back(mk(0, 1, 0, 0, 1, al, wd, 0));
            expq.push_back(mk(0, 0, 1, 0, 0, al, 0, 0));
        end else begin
            res = old - (((old >> sh) & m) << sh) + ((wd & m) << sh);
            for (int i = 0; i < RD_LAT; i++) expq.push_back(mk(1, 0, 0, 0, 1, al, 0, 0));
            expq.push_back(mk(0, 1, 0, 0, 1, al, res, 0));
            expq.push_back(mk(0, 0, 1, 0, 0, al, 0, 0));
        end
    endfunction

    // Model: advances one cycle per edge; a write commits at the edge ending it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expq.delete();
            cur = '0;
            cur.achk = 1'b1;
        end else begin
            if (cur.wr) ref_mem[cur.addr[14:2]] = cur.wdata;
            if (cur.rdy && req_valid) gen(req_write, req_size, req_signed, req_addr, req_wdata);
            if (expq.size() > 0) cur = expq.pop_front();
            else begin
                cur = '0;
                cur.rdy = 1'b1;
                cur.achk = 1'b1;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("ctl{ready,read,write,rvalid,err}",
            {27'b0, req_ready, mem_read, mem_write, resp_valid, resp_err},
            {27'b0, cur.rdy, cur.rd, cur.wr, cur.rv, cur.err});
        if (cur.achk) chk("mem_addr", mem_addr, cur.addr);
        chk("mem_wdata", mem_wdata, cur.wdata);
        chk("resp_rdata", resp_rdata, cur.rdata);
    end

    // Issue one request when the model is idle and observe it to completion.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic err, output logic [31:0] rdata,
                         output int nrd, output int nwr, output logic [31:0] wdat,
                         output logic [31:0] waddr);
        int t;
        t = 0;
        @(negedge clk);
        while (!cur.rdy && t < 50) begin @(negedge clk); t++; end
        #1;
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        nrd = 0; nwr = 0; wdat = '0; waddr = '0;
        for (lat = 1; lat <= 10; lat++) begin
            @(negedge clk);
            if (mem_read) nrd++;
            if (mem_write) begin nwr++; wdat = mem_wdata; waddr = mem_addr; end
            if (resp_valid) break;
        end
        err = resp_err;
        rdata = resp_rdata;
        if (lat > 10) begin
            n_cmp++; n_bad++;
            $display("FAIL resp_timeout: no resp_valid within 10 cycles for addr %h", a);
        end
    endtask

    initial begin
        int lat, nrd, nwr, t;
        logic err;
        logic [31:0] rd, wdat, waddr, w, v;
        int r;

        for (int i = 0; i < MEM_WORDS; i++) begin
            v = $urandom;
            ram[i] = v;
            ref_mem[i] = v;
        end
        cur = '0;
        cur.achk = 1'b1;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ready", {31'b0, req_ready}, 32'd0);
        chk("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        #1 rst_n = 1'b1;

        // 1: word store
        issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, lat, err, rd, nrd, nwr, wdat, waddr);
        chk("t1 latency", lat, 2);
        chk("t1 err", {31'b0, err}, 0);
        chk("t1 reads", nrd, 0);
        chk("t1 writes", nwr, 1);
        chk("t1 wdata", wdat, 32'hDEADBEEF);
        chk("t1 waddr", waddr, 32'h10);

        // 2: loads with extension
        issue(0, 2'b00, 1, 32'h13, 0, lat, err, rd, nrd, nwr, wdat, waddr);
        chk("t2 lb 0x13", rd, 32'hFFFFFFDE);
        chk("t2 lb latency", lat, 2);
        issue(0, 2'b00, 0, 32'h13, 0, lat, err, rd, nrd, nwr, wdat, waddr);
        chk("t2 lbu 0x13", rd, 32'h000000DE);
        issue(0, 2'b01, 1, 32'h12, 0, lat, err, rd, nrd, nwr, wdat, waddr);
        chk("t2 lh 0x12", rd, 32'hFFFFDEAD);
        issue(0, 2'b01, 0, 32'h10, 0, lat, err, rd, nrd, nwr, wdat, waddr);
        chk("t2 lhu 0x10", rd, 32'h0000BEEF);
        chk("t2 lhu latency", lat, 2);

        // 3: byte store read-modify-write
        issue(1, 2'b00, 0, 32'h11, 32'h55, lat, err, rd, nrd, nwr, wdat, waddr);
        chk("t3 reads", nrd, 1);
        chk("t3 writes", nwr, 1);
        chk("t3 merged", wdat, 32'hDEAD55EF);
        chk("t3 latency", lat, 3);

        // 4: misaligned word and illegal size
        issue(0, 2'b10, 0, 32'h0E, 0, lat, err, rd, nrd, nwr, wdat, waddr);
        chk("t4 misalign err", {31'b0, err}, 1);
        chk("t4 misalign rdata", rd, 0);
        chk("t4 misalign latency", lat, 1);
        chk("t4 misalign strobes", nrd + nwr, 0);
        issue(0, 2'b11, 0, 32'h20, 0, lat, err, rd, nrd, nwr, wdat, waddr);
        chk("t4 size11 err", {31'b0, err}, 1);
        chk("t4 size11 latency", lat, 1);
        chk("t4 size11 strobes", nrd + nwr, 0);

        // 5: range boundary
        issue(1, 2'b10, 0, 32'h7FFC, 32'h12345678, lat, err, rd, nrd, nwr, wdat, waddr);
        issue(0, 2'b10, 0, 32'h8000, 0, lat, err, rd, nrd, nwr, wdat, waddr);
        chk("t5 0x8000 err", {31'b0, err}, 1);
        chk("t5 0x8000 latency", lat, 1);
        issue(0, 2'b10, 0, 32'h7FFC, 0, lat, err, rd, nrd, nwr, wdat, waddr);
        chk("t5 0x7FFC err", {31'b0, err}, 0);
        chk("t5 0x7FFC data", rd, 32'h12345678);

        // 6: reset during the read phase of a byte store
        issue(1, 2'b10, 0, 32'h20, 32'hCAFEF00D, lat, err, rd, nrd, nwr, wdat, waddr);
        @(negedge clk);
        t = 0;
        while (!cur.rdy && t < 50) begin @(negedge clk); t++; end
        #1;
        req_write = 1; req_size = 2'b00; req_signed = 0; req_addr = 32'h21; req_wdata = 32'h77;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("t6 reading", {31'b0, mem_read}, 1);
        #1 rst_n = 1'b0;
        #1 chk("t6 drop at reset", {28'b0, req_ready, mem_read, mem_write, resp_valid}, 0);
        repeat (2) @(negedge clk);
        chk("t6 held in reset", {28'b0, req_ready, mem_read, mem_write, resp_valid}, 0);
        #1 rst_n = 1'b1;
        #1 chk("t6 ready before edge", {31'b0, req_ready}, 0);
        @(negedge clk);
        chk("t6 ready after edge", {31'b0, req_ready}, 1);
        chk("t6 ram untouched", ram[8], 32'hCAFEF00D);
        issue(0, 2'b10, 0, 32'h20, 0, lat, err, rd, nrd, nwr, wdat, waddr);
        chk("t6 reload", rd, 32'hCAFEF00D);
        chk("t6 reload latency", lat, 2);

        // Random traffic, including requests while busy and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
            req_valid  = ($urandom_range(0, 2) == 0);
            req_write  = 1'($urandom_range(0, 1));
            req_signed = 1'($urandom_range(0, 1));
            req_size   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            req_wdata  = $urandom;
            r = $urandom_range(0, 19);
            if (r < 14)      w = $urandom_range(0, 15);
            else if (r < 18) w = 8188 + $urandom_range(0, 3);
            else if (r < 19) w = 8192 + $urandom_range(0, 7);
            else             w = $urandom;
            req_addr = {w[29:0], 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 0) begin
                if (req_size == 2'b01) req_addr[0] = 1'b0;
                if (req_size == 2'b10) req_addr[1:0] = 2'b00;
            end
        end
        @(negedge clk);
        #1 req_valid = 1'b0;
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: converts CPU load/store requests into word-wide read/write strobes on the data memory.
- Supports byte, halfword and word accesses, and sign/zero extension on loads.
- Sub-word stores use read-modify-write because the memory is word-addressed only.
- Sits between the execute stage and the data memory; one request in flight at a time.

Parameters:
- RD_LAT, 1, memory read latency in cycles from mem_read assertion to valid mem_rdata (legal 1..3).
- MEM_WORDS, 8192, number of 32-bit words in data memory; word index >= MEM_WORDS is out of range.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  unit idle and able to accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  access rejected, qualified by resp_valid.
- mem_addr  out  32  word-aligned byte address, {addr[31:2],2'b00}.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_wdata  out  32  full word to write; 0 when mem_write=0.
- mem_rdata  in  32  memory read data.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0, including req_ready.
  - req_ready rises on the first clock edge after rst_n deasserts.
- States: IDLE, RD_WAIT, WRITE, RESP.
  - req_ready=1 only in IDLE.
  - A request is accepted on the edge where req_valid && req_ready; all request fields are latched at that edge.
- Error check at accept. Any of the following goes IDLE->RESP with no memory strobes, then resp_err=1 and resp_rdata=0:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= MEM_WORDS.
- Load: IDLE->RD_WAIT.
  - mem_read=1 for RD_LAT cycles.
  - mem_rdata is captured at the last RD_WAIT edge.
  - Lane is selected little-endian: byte lane addr[1:0], half lane addr[1]. The lane is then extended per req_signed.
  - Then ->RESP.
- Word store: IDLE->WRITE (mem_write=1, mem_wdata=req_wdata for one cycle), then ->RESP.
- Sub-word store: IDLE->RD_WAIT (read as for a load), then the addressed lane is merged with req_wdata[7:0] or [15:0], then ->WRITE with the merged word, then ->RESP.
- RESP: resp_valid=1 for exactly one cycle, then ->IDLE. req_ready returns to 1 in the following cycle.
- Latency, with accept at edge k (cycle of resp_valid):
  - error: k+1;
  - word store: k+2;
  - load: k+RD_LAT+1;
  - sub-word store: k+RD_LAT+2.
- Invariants:
  - mem_read and mem_write are never high together.
  - mem_addr is held stable for the whole access and is 0 in IDLE.
  - resp_rdata is held only during resp_valid; it is 0 otherwise.
- Reset mid-operation: strobes drop immediately. No write is issued for an interrupted read-modify-write, and no response is produced.
- req_valid while not ready is ignored (not queued).

Optional Feature:
- LSU_STATS_EN defined: adds outputs stat_loads, stat_stores, stat_errs, each 16 bits.
  - Each increments by 1 on the resp_valid cycle of the matching completion; error completions count in stat_errs only.
  - Counters saturate at 0xFFFF and reset to 0.
- LSU_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enum lsu_state_t;
  - default MEM_WORDS constant.
- Sub-module lsu_lane_align (combinational) holds:
  - load extract/extend from word, addr[1:0], size and signed;
  - store merge of old word with new data by lane.
- The FSM stays in load_store_unit.

Test Plan:
All scenarios use RD_LAT=1 and a behavioural memory model.
1. Store word 0xDEADBEEF to addr 0x10, accepted at edge k -> one cycle with mem_write=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; resp_valid at k+2 with resp_err=0; mem_read never high.
2. Memory word 0x10 = 0xDEADBEEF:
   - load byte signed 0x13 -> 0xFFFFFFDE;
   - load byte unsigned 0x13 -> 0x000000DE;
   - load half signed 0x12 -> 0xFFFFDEAD;
   - load half unsigned 0x10 -> 0x0000BEEF.
   Each response arrives at k+2.
3. Store byte 0x55 to 0x11 over 0xDEADBEEF -> one mem_read cycle, then one mem_write cycle with mem_wdata=0xDEAD55EF; resp_valid at k+3.
4. Word load at 0x0E, then a request with size 11 -> each gives resp_valid with resp_err=1 at k+1 and resp_rdata=0; no mem strobes.
5. Word load at 0x8000 (word index 8192) -> resp_err=1; word load at 0x7FFC -> normal data.
6. rst_n pulled low during RD_WAIT of a byte store -> no mem_write ever, no resp_valid, req_ready=0 during reset and 1 one edge after release; a subsequent word load completes correctly.
